// File: rtl/writeback_stage.sv
// MEM/WB stage register and writeback logic: drives the register-file write port into decode,
// extracts/extends load data and counts retired instructions.
module writeback_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_wb_reg_file,
  input  logic             ex_memtoreg,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic             ex_lui,
  input  logic [2:0]       ex_load_type,
  input  logic [1:0]       ex_addr_lo,
  input  logic [31:0]      ex_alu_result,
  input  logic [31:0]      ex_pc_plus4,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      mem_rdata,
  output logic             wb_wr_en,
  output logic [4:0]       wb_wr_addr,
  output logic [31:0]      wb_wr_data,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  // Byte/half selection from the aligned word; unknown load types behave as LW.
  function automatic logic [31:0] extract_load(input logic [2:0]  load_type,
                                               input logic [1:0]  addr_lo,
                                               input logic [31:0] word);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] res;
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (load_type)
      LT_LB:   res = {{24{byte_sel[7]}}, byte_sel};
      LT_LH:   res = {{16{half_sel[15]}}, half_sel};
      LT_LBU:  res = {24'd0, byte_sel};
      LT_LHU:  res = {16'd0, half_sel};
      default: res = word;
    endcase
    return res;
  endfunction

  logic             valid_r;
  logic             committed_r;
  logic [31:0]      hold_r;
  logic [4:0]       rd_r;
  logic             wb_reg_file_r;
  logic             memtoreg_r;
  logic             link_r;
  logic             lui_r;
  logic [2:0]       load_type_r;
  logic [1:0]       addr_lo_r;
  logic [31:0]      alu_result_r;
  logic [31:0]      pc_plus4_r;
  logic [31:0]      imm_r;
  logic [CNT_W-1:0] instret_r;

  logic             retire_s;
  logic [31:0]      load_word_s;
  logic [31:0]      sel_data_s;

  // Stage register: capture when free, hold on stall, kill on flush (flush wins over stall).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r       <= 1'b0;
      committed_r   <= 1'b0;
      hold_r        <= 32'd0;
      rd_r          <= 5'd0;
      wb_reg_file_r <= 1'b0;
      memtoreg_r    <= 1'b0;
      link_r        <= 1'b0;
      lui_r         <= 1'b0;
      load_type_r   <= 3'b000;
      addr_lo_r     <= 2'b00;
      alu_result_r  <= 32'd0;
      pc_plus4_r    <= 32'd0;
      imm_r         <= 32'd0;
    end else if (flush) begin
      valid_r     <= 1'b0;
      committed_r <= 1'b0;
    end else if (stall) begin
      committed_r <= valid_r;
      // Freeze the memory word seen when the entry was first presented.
      if (!committed_r) begin
        hold_r <= mem_rdata;
      end
    end else begin
      valid_r       <= ex_valid;
      committed_r   <= 1'b0;
      rd_r          <= ex_rd;
      wb_reg_file_r <= ex_wb_reg_file;
      memtoreg_r    <= ex_memtoreg;
      link_r        <= ex_jal | ex_jalr;
      lui_r         <= ex_lui;
      load_type_r   <= ex_load_type;
      addr_lo_r     <= ex_addr_lo;
      alu_result_r  <= ex_alu_result;
      pc_plus4_r    <= ex_pc_plus4;
      imm_r         <= ex_imm;
    end
  end

  // Writeback value selection and register-file port drive.
  always_comb begin
    retire_s    = valid_r & ~committed_r;
    load_word_s = committed_r ? hold_r : mem_rdata;
    if (link_r) begin
      sel_data_s = pc_plus4_r;
    end else if (lui_r) begin
      sel_data_s = imm_r;
    end else if (memtoreg_r) begin
      sel_data_s = extract_load(load_type_r, addr_lo_r, load_word_s);
    end else begin
      sel_data_s = alu_result_r;
    end
    if (valid_r) begin
      wb_wr_en   = retire_s & wb_reg_file_r & (rd_r != 5'd0);
      wb_wr_addr = rd_r;
      wb_wr_data = sel_data_s;
    end else begin
      wb_wr_en   = 1'b0;
      wb_wr_addr = 5'd0;
      wb_wr_data = 32'd0;
    end
  end

  // Retire counter: one count per entry, on the edge that ends its first presented cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_r <= instret_r;
    end
  end

  assign instret = instret_r;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage against an entry-level reference model.
module tb_writeback_stage;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             flush;
  logic             ex_valid;
  logic [4:0]       ex_rd;
  logic             ex_wb_reg_file;
  logic             ex_memtoreg;
  logic             ex_jal;
  logic             ex_jalr;
  logic             ex_lui;
  logic [2:0]       ex_load_type;
  logic [1:0]       ex_addr_lo;
  logic [31:0]      ex_alu_result;
  logic [31:0]      ex_pc_plus4;
  logic [31:0]      ex_imm;
  logic [31:0]      mem_rdata;
  logic             wb_wr_en;
  logic [4:0]       wb_wr_addr;
  logic [31:0]      wb_wr_data;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  writeback_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wb_reg_file(ex_wb_reg_file),
    .ex_memtoreg(ex_memtoreg), .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_lui(ex_lui),
    .ex_load_type(ex_load_type), .ex_addr_lo(ex_addr_lo), .ex_alu_result(ex_alu_result),
    .ex_pc_plus4(ex_pc_plus4), .ex_imm(ex_imm), .mem_rdata(mem_rdata),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data), .instret(instret)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the entry in the stage, whether it has already been on the port, and its load word.
  bit          m_valid = 1'b0;
  bit          m_seen = 1'b0;
  logic [31:0] m_word = 32'd0;
  logic [4:0]  m_rd = 5'd0;
  bit          m_wbrf, m_mtr, m_link, m_lui;
  logic [2:0]  m_lt;
  logic [1:0]  m_alo;
  logic [31:0] m_alu, m_pc4, m_imm;
  logic [31:0] m_count = 32'd0;

  function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [1:0] alo, input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * alo)) & 32'h0000_00FF;
    h = (w >> (16 * (alo / 2))) & 32'h0000_FFFF;
    case (lt)
      3'd0:    return (b < 32'd128)   ? b : b + 32'hFFFF_FF00;
      3'd1:    return (h < 32'd32768) ? h : h + 32'hFFFF_0000;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic rand_inputs();
    ex_valid       = ($urandom_range(0, 3) != 0);
    ex_rd          = 5'($urandom_range(0, 31));
    ex_wb_reg_file = ($urandom_range(0, 3) != 0);
    ex_memtoreg    = ($urandom_range(0, 2) == 0);
    ex_jal         = ($urandom_range(0, 7) == 0);
    ex_jalr        = ($urandom_range(0, 7) == 0);
    ex_lui         = ($urandom_range(0, 7) == 0);
    ex_load_type   = 3'($urandom_range(0, 7));
    ex_addr_lo     = 2'($urandom_range(0, 3));
    ex_alu_result  = $urandom;
    ex_pc_plus4    = $urandom;
    ex_imm         = $urandom;
    mem_rdata      = $urandom;
  endtask

  task automatic plain_entry(input logic [4:0] rd);
    ex_valid = 1'b1; ex_rd = rd; ex_wb_reg_file = 1'b1; ex_memtoreg = 1'b0;
    ex_jal = 1'b0; ex_jalr = 1'b0; ex_lui = 1'b0;
  endtask

  // One clock: check outputs at negedge, advance model across the posedge, return #1 after it.
  task automatic step(input string tag, input bit use_want, input logic [31:0] want);
    logic [31:0] exp_data;
    logic [31:0] word;
    bit          exp_en;
    @(negedge clk);
    if (!rst) begin
      m_valid = 1'b0; m_seen = 1'b0; m_count = 32'd0;
    end
    word = m_seen ? m_word : mem_rdata;
    if (!m_valid)    exp_data = 32'd0;
    else if (m_link) exp_data = m_pc4;
    else if (m_lui)  exp_data = m_imm;
    else if (m_mtr)  exp_data = ref_load(m_lt, m_alo, word);
    else             exp_data = m_alu;
    exp_en = m_valid && !m_seen && m_wbrf && (m_rd != 5'd0);
    check({tag, ".en"}, 64'(wb_wr_en), 64'(exp_en));
    check({tag, ".addr"}, 64'(wb_wr_addr), m_valid ? 64'(m_rd) : 64'd0);
    check({tag, ".data"}, 64'(wb_wr_data), 64'(exp_data));
    check({tag, ".instret"}, 64'(instret), 64'(m_count));
    if (use_want) check({tag, ".want"}, 64'(wb_wr_data), 64'(want));
    if (rst) begin
      if (m_valid && !m_seen) m_count = m_count + 32'd1;
      if (flush) begin
        m_valid = 1'b0; m_seen = 1'b0;
      end else if (stall) begin
        if (!m_seen) m_word = mem_rdata;
        m_seen = m_valid;
      end else begin
        m_valid = ex_valid; m_seen = 1'b0;
        m_rd = ex_rd; m_wbrf = ex_wb_reg_file; m_mtr = ex_memtoreg;
        m_link = ex_jal | ex_jalr; m_lui = ex_lui; m_lt = ex_load_type; m_alo = ex_addr_lo;
        m_alu = ex_alu_result; m_pc4 = ex_pc_plus4; m_imm = ex_imm;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  lt_tab  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]  alo_tab [5] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1};
  logic [31:0] want_tab[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_0000};

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    rand_inputs();
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      stall = 1'($urandom_range(0, 1));
      step("reset", 1'b1, 32'd0);
    end
    rst = 1'b1; stall = 1'b0; flush = 1'b0;

    // ALU writeback
    rand_inputs(); plain_entry(5'd5); ex_alu_result = 32'h0000_1234;
    step("alu_cap", 1'b0, 32'd0);
    ex_valid = 1'b0;
    step("alu", 1'b1, 32'h0000_1234);
    step("alu_after", 1'b0, 32'd0);

    // Load extraction table
    for (int i = 0; i < 5; i++) begin
      rand_inputs(); plain_entry(5'd7);
      ex_memtoreg = 1'b1; ex_load_type = lt_tab[i]; ex_addr_lo = alo_tab[i];
      step("load_cap", 1'b0, 32'd0);
      ex_valid = 1'b0; mem_rdata = 32'h80FF_0000;
      step($sformatf("load%0d", i), 1'b1, want_tab[i]);
    end

    // rd = 0 still retires
    rand_inputs(); plain_entry(5'd0);
    step("rd0_cap", 1'b0, 32'd0);
    ex_valid = 1'b0;
    step("rd0", 1'b0, 32'd0);

    // Load held across a 3-cycle stall while mem_rdata changes
    rand_inputs(); plain_entry(5'd9); ex_memtoreg = 1'b1; ex_load_type = 3'b010;
    step("hold_cap", 1'b0, 32'd0);
    stall = 1'b1; rand_inputs(); mem_rdata = 32'hCAFE_0001;
    step("hold0", 1'b1, 32'hCAFE_0001);
    for (int i = 1; i < 3; i++) begin
      rand_inputs();
      step($sformatf("hold%0d", i), 1'b1, 32'hCAFE_0001);
    end
    stall = 1'b0; rand_inputs();
    step("hold_end", 1'b1, 32'hCAFE_0001);

    // jal beats memtoreg; flush during stall
    rand_inputs(); plain_entry(5'd3); ex_jal = 1'b1; ex_memtoreg = 1'b1; ex_pc_plus4 = 32'h0000_0100;
    step("jal_cap", 1'b0, 32'd0);
    stall = 1'b1; rand_inputs();
    step("jal", 1'b1, 32'h0000_0100);
    flush = 1'b1;
    step("jal_flush", 1'b1, 32'h0000_0100);
    stall = 1'b0; flush = 1'b0; ex_valid = 1'b0;
    step("after_flush", 1'b1, 32'd0);

    // Reset during a stall discards the entry
    rand_inputs(); plain_entry(5'd11);
    step("rst_cap", 1'b0, 32'd0);
    stall = 1'b1;
    step("rst_pres", 1'b0, 32'd0);
    rst = 1'b0;
    step("rst_mid", 1'b1, 32'd0);
    rst = 1'b1;
    step("rst_after", 1'b1, 32'd0);
    stall = 1'b0;

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 99) != 0);
      step("rand", 1'b0, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
